alu_arbiter: RTL

- Shares one combinational ALU between two requesters, e.g. the execute stage (port 0) and the address/branch-compare unit (port 1).
- Accepts one operation at a time through a valid/ready handshake and registers the operands.
- Drives the shared ALU for ALU_LAT cycles, then returns the registered result to the granted requester.
- Round-robin arbitration guarantees neither requester starves.

---
 rtl/alu_arbiter_if.sv | 52 +++++
 rtl/alu_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Requester, response and shared-ALU signals of alu_arbiter, grouped for port connection.
// rsp_err exists only when ALU_ARB_OPCHK_EN is defined.
interface alu_arbiter_if #(
   parameter int WIDTH = 32
);
   logic             req0_valid;
   logic             req0_ready;
   logic [5:0]       req0_alucontrol;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic             req1_valid;
   logic             req1_ready;
   logic [5:0]       req1_alucontrol;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic             rsp0_valid;
   logic             rsp1_valid;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_zero;
`ifdef ALU_ARB_OPCHK_EN
   logic             rsp_err;
`endif
   logic [5:0]       alu_control;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_result;
   logic             alu_zero;

   // Arbiter side
   modport slave (
      input  req0_valid, req0_alucontrol, req0_a, req0_b,
      input  req1_valid, req1_alucontrol, req1_a, req1_b,
      input  alu_result, alu_zero,
`ifdef ALU_ARB_OPCHK_EN
      output rsp_err,
`endif
      output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
      output rsp_result, rsp_zero, alu_control, alu_a, alu_b
   );

   // Requesters plus the shared ALU
   modport master (
      output req0_valid, req0_alucontrol, req0_a, req0_b,
      output req1_valid, req1_alucontrol, req1_a, req1_b,
      output alu_result, alu_zero,
`ifdef ALU_ARB_OPCHK_EN
      input  rsp_err,
`endif
      input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
      input  rsp_result, rsp_zero, alu_control, alu_a, alu_b
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters (IDLE/BUSY/DONE FSM).
// Optional ALU_ARB_OPCHK_EN: illegal opcodes bypass the ALU and return rsp_err.
module alu_arbiter #(
   parameter int WIDTH   = 32,
   parameter int ALU_LAT = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   alu_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(ALU_LAT - 1);
   localparam logic [5:0] OP_ADD   = 6'b000010;
`ifdef ALU_ARB_OPCHK_EN
   localparam logic [5:0] OP_SUB   = 6'b100010;
   localparam logic [5:0] OP_AND   = 6'b000000;
   localparam logic [5:0] OP_OR    = 6'b000001;
   localparam logic [5:0] OP_SLT   = 6'b100011;
`endif

   state_t           state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             id_q, id_d;
   logic [5:0]       ctl_q, ctl_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
`ifdef ALU_ARB_OPCHK_EN
   logic             err_q, err_d;
   logic             op_legal;
`endif

   logic             grant;
   logic             ready0, ready1, accept;
   logic [5:0]       op_in;
   logic [WIDTH-1:0] a_in, b_in;

   // On a tie the port that was not served last wins
   always_comb begin
      grant = 1'b0;
      if (bus.req0_valid && bus.req1_valid) begin
         grant = ~last_grant_q;
      end else if (bus.req1_valid) begin
         grant = 1'b1;
      end
   end

   assign ready0 = (state_q == IDLE) && bus.req0_valid && !grant;
   assign ready1 = (state_q == IDLE) && bus.req1_valid && grant;
   assign accept = ready0 || ready1;
   assign op_in  = grant ? bus.req1_alucontrol : bus.req0_alucontrol;
   assign a_in   = grant ? bus.req1_a : bus.req0_a;
   assign b_in   = grant ? bus.req1_b : bus.req0_b;

`ifdef ALU_ARB_OPCHK_EN
   always_comb begin
      case (op_in)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: op_legal = 1'b1;
         default:                               op_legal = 1'b0;
      endcase
   end
`endif

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      id_d         = id_q;
      ctl_d        = ctl_q;
      a_d          = a_q;
      b_d          = b_q;
      result_d     = result_q;
      zero_d       = zero_q;
`ifdef ALU_ARB_OPCHK_EN
      err_d        = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               id_d         = grant;
               last_grant_d = grant;
               cnt_d        = CNT_LOAD;
`ifdef ALU_ARB_OPCHK_EN
               if (op_legal) begin
                  ctl_d   = op_in;
                  a_d     = a_in;
                  b_d     = b_in;
                  err_d   = 1'b0;
                  state_d = BUSY;
               end else begin
                  // ALU operand registers stay untouched so the ALU sees no activity
                  result_d = '0;
                  zero_d   = 1'b0;
                  err_d    = 1'b1;
                  state_d  = DONE;
               end
`else
               ctl_d   = op_in;
               a_d     = a_in;
               b_d     = b_in;
               state_d = BUSY;
`endif
            end
         end
         BUSY: begin
            if (cnt_q == 4'd0) begin
               result_d = bus.alu_result;
               zero_d   = bus.alu_zero;
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         cnt_q        <= 4'd0;
         id_q         <= 1'b0;
         ctl_q        <= OP_ADD;
         a_q          <= '0;
         b_q          <= '0;
         result_q     <= '0;
         zero_q       <= 1'b0;
`ifdef ALU_ARB_OPCHK_EN
         err_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         id_q         <= id_d;
         ctl_q        <= ctl_d;
         a_q          <= a_d;
         b_q          <= b_d;
         result_q     <= result_d;
         zero_q       <= zero_d;
`ifdef ALU_ARB_OPCHK_EN
         err_q        <= err_d;
`endif
      end
   end

   assign bus.req0_ready  = ready0;
   assign bus.req1_ready  = ready1;
   assign bus.rsp0_valid  = (state_q == DONE) && !id_q;
   assign bus.rsp1_valid  = (state_q == DONE) && id_q;
   assign bus.rsp_result  = result_q;
   assign bus.rsp_zero    = zero_q;
   assign bus.alu_control = ctl_q;
   assign bus.alu_a       = a_q;
   assign bus.alu_b       = b_q;
`ifdef ALU_ARB_OPCHK_EN
   assign bus.rsp_err     = err_q;
`endif
endmodule
